// File: rtl/tbc_arbiter.sv
// tbc_arbiter: round-robin arbiter sequencing NREQ requesters onto one shared masked SKINNY core
module tbc_arbiter #(
    parameter int NREQ = 2,
    parameter int D    = 2,
    parameter int W    = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       hold,
    input  logic [NREQ*W-1:0]     tk1_in,
    input  logic [NREQ*W-1:0]     tk2_in,
    input  logic [NREQ*W*D-1:0]   tk3_in,
    input  logic [NREQ*W*D-1:0]   st_in,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done_out,
    output logic [W*D-1:0]        st_out,
    output logic                  busy,
    output logic                  core_start,
    output logic                  core_reset,
    output logic [W-1:0]          core_tk1,
    output logic [W-1:0]          core_tk2,
    output logic [W*D-1:0]        core_tk3,
    output logic [W*D-1:0]        core_st,
    input  logic [W*D-1:0]        core_st_out,
    input  logic                  core_done
);
    localparam int PW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [W*D-1:0]  st_q, st_d;
    logic [PW-1:0]   g_idx, ptr_nxt;
    logic [NREQ-1:0] mask, hi, sel, pick;
    logic            g_req, g_hold, rel;

    // Prefer requesters at or above ptr; wrap to the lowest set bit otherwise.
    assign mask = ~((NREQ'(1) << ptr_q) - NREQ'(1));
    assign hi   = req & mask;
    assign sel  = |hi ? hi : req;
    assign pick = sel & (~sel + NREQ'(1));

    assign g_req   = |(req & gnt_q);
    assign g_hold  = |(hold & gnt_q);
    assign ptr_nxt = (g_idx == PW'(NREQ - 1)) ? '0 : g_idx + PW'(1);

    always_comb begin
        g_idx = '0;
        for (int i = 0; i < NREQ; i++) if (gnt_q[i]) g_idx = PW'(i);
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        done_d  = '0;
        st_d    = st_q;
        rel     = 1'b0;
        case (state_q)
            IDLE:  if (|req) begin
                       gnt_d   = pick;
                       state_d = ISSUE;
                   end
            ISSUE: state_d = WAIT;
            WAIT:  if (core_done) begin
                       st_d    = core_st_out;
                       done_d  = gnt_q;
                       state_d = g_hold ? HOLD : state_q;
                       rel     = !g_hold;
                   end
            HOLD:  if (g_req) state_d = ISSUE;
                   else rel = !g_hold;
            default: state_d = IDLE;
        endcase
        if (rel) begin
            gnt_d   = '0;
            ptr_d   = ptr_nxt;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
            done_q  <= '0;
            st_q    <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
            st_q    <= st_d;
        end
    end

    // AND-OR mux keyed on the one-hot grant: nothing reaches the core while ungranted.
    always_comb begin
        core_tk1 = '0;
        core_tk2 = '0;
        core_tk3 = '0;
        core_st  = '0;
        for (int i = 0; i < NREQ; i++) begin
            core_tk1 = core_tk1 | ({W{gnt_q[i]}} & tk1_in[W*i +: W]);
            core_tk2 = core_tk2 | ({W{gnt_q[i]}} & tk2_in[W*i +: W]);
            core_tk3 = core_tk3 | ({(W*D){gnt_q[i]}} & tk3_in[W*D*i +: W*D]);
            core_st  = core_st  | ({(W*D){gnt_q[i]}} & st_in[W*D*i +: W*D]);
        end
    end

    assign gnt        = gnt_q;
    assign done_out   = done_q;
    assign st_out     = st_q;
    assign busy       = |gnt_q;
    assign core_start = (state_q == ISSUE);
    assign core_reset = !rst_n || (state_q == IDLE);
endmodule

// File: tb/tb_tbc_arbiter.sv
// tb_tbc_arbiter: randomized call sequences against a transaction-level round-robin model
module tb_tbc_arbiter;
    localparam int NREQ = 4;
    localparam int D    = 2;
    localparam int W    = 32;
    localparam int WD   = W * D;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req, hold, gnt, done_out;
    logic [NREQ*W-1:0]    tk1_in, tk2_in;
    logic [NREQ*WD-1:0]   tk3_in, st_in;
    logic [WD-1:0]        st_out, core_tk3, core_st, core_st_out;
    logic [W-1:0]         core_tk1, core_tk2;
    logic                 busy, core_start, core_reset, core_done;

    int            n_vec = 0;
    int            n_err = 0;
    int            m_ptr = 0;
    logic [WD-1:0] exp_st = '0;

    tbc_arbiter #(.NREQ(NREQ), .D(D), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .hold(hold),
        .tk1_in(tk1_in), .tk2_in(tk2_in), .tk3_in(tk3_in), .st_in(st_in),
        .gnt(gnt), .done_out(done_out), .st_out(st_out), .busy(busy),
        .core_start(core_start), .core_reset(core_reset),
        .core_tk1(core_tk1), .core_tk2(core_tk2), .core_tk3(core_tk3), .core_st(core_st),
        .core_st_out(core_st_out), .core_done(core_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WD-1:0] got, input logic [WD-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rr(input logic [NREQ-1:0] r);
        int j;
        for (int k = 0; k < NREQ; k++) begin
            j = (m_ptr + k) % NREQ;
            if (r[j[1:0]]) return j;
        end
        return 0;
    endfunction

    task automatic check_ops(input int w);
        check("tk1_mux", core_tk1, tk1_in[W*w +: W]);
        check("tk2_mux", core_tk2, tk2_in[W*w +: W]);
        check("tk3_mux", core_tk3, tk3_in[WD*w +: WD]);
        check("st_mux", core_st, st_in[WD*w +: WD]);
    endtask

    task automatic check_zero();
        check("tk1_zero", core_tk1, '0);
        check("tk2_zero", core_tk2, '0);
        check("tk3_zero", core_tk3, '0);
        check("st_zero", core_st, '0);
    endtask

    task automatic check_reset_vals();
        check("rst_gnt", gnt, '0);
        check("rst_done", done_out, '0);
        check("rst_st_out", st_out, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_start", core_start, 1'b0);
        check("rst_core_reset", core_reset, 1'b1);
    endtask

    task automatic run_round(input logic [NREQ-1:0] r, input int ncalls);
        int w, lat, nw;
        logic [NREQ-1:0] eg;
        logic [WD-1:0] v;
        bit hv, last;
        for (int i = 0; i < NREQ; i++) begin
            tk1_in[W*i +: W] = $urandom;
            tk2_in[W*i +: W] = $urandom;
        end
        for (int i = 0; i < NREQ * D; i++) begin
            tk3_in[32*i +: 32] = $urandom;
            st_in[32*i +: 32]  = $urandom;
        end
        req  = r;
        hold = NREQ'($urandom);
        w    = rr(r);
        eg   = NREQ'(1) << w;
        tick();
        check("gnt_issue", gnt, eg);
        check("start_issue", core_start, 1'b1);
        check("busy_issue", busy, 1'b1);
        check("core_reset_issue", core_reset, 1'b0);
        check_ops(w);
        for (int c = 0; c < ncalls; c++) begin
            last = (c == ncalls - 1);
            lat  = $urandom_range(1, 5);
            for (int k = 0; k < lat; k++) begin
                if (last && $urandom_range(0, 3) == 0) req[w] = 1'b0;
                hold = NREQ'($urandom);
                tick();
                check("start_once", core_start, 1'b0);
                check("done_early", done_out, '0);
                check("gnt_wait", gnt, eg);
            end
            hv          = last ? bit'($urandom_range(0, 1)) : 1'b1;
            hold        = NREQ'($urandom);
            hold[w]     = hv;
            v           = {$urandom, $urandom};
            core_done   = 1'b1;
            core_st_out = v;
            tick();
            core_done   = 1'b0;
            core_st_out = {$urandom, $urandom};
            exp_st      = v;
            check("done_pulse", done_out, eg);
            check("st_out", st_out, v);
            if (!last) begin
                check("gnt_hold", gnt, eg);
                nw      = $urandom_range(0, 2);
                req[w]  = (nw == 0);
                hold[w] = 1'b1;
                for (int k = 0; k < nw; k++) begin
                    tick();
                    check("hold_no_start", core_start, 1'b0);
                    check("gnt_hold_wait", gnt, eg);
                    check("done_once_hold", done_out, '0);
                    req[w] = (k == nw - 1);
                end
                tick();
                check("start_reissue", core_start, 1'b1);
                check("gnt_reissue", gnt, eg);
                check_ops(w);
            end else begin
                req[w] = 1'b0;
                if (hv) begin
                    check("gnt_hold_last", gnt, eg);
                    hold[w] = 1'b0;
                    tick();
                    check("done_once", done_out, '0);
                end
                check("gnt_release", gnt, '0);
                check("busy_release", busy, 1'b0);
                check("core_reset_idle", core_reset, 1'b1);
                check_zero();
                m_ptr = (w + 1) % NREQ;
            end
        end
    endtask

    task automatic idle_done();
        req         = '0;
        core_done   = 1'b1;
        core_st_out = {$urandom, $urandom};
        tick();
        core_done = 1'b0;
        check("st_keep_idle", st_out, exp_st);
        check("done_idle", done_out, '0);
        check("gnt_idle", gnt, '0);
    endtask

    initial begin
        int w;
        rst_n = 1'b0;
        req = '0; hold = '0; core_done = 1'b0; core_st_out = '0;
        tk1_in = '0; tk2_in = '0; tk3_in = '0; st_in = '0;
        tick();
        tick();
        check_reset_vals();
        rst_n = 1'b1;
        repeat (5) begin
            tick();
            check("idle_start", core_start, 1'b0);
            check("idle_gnt", gnt, '0);
            check("idle_core_reset", core_reset, 1'b1);
        end
        run_round(4'b0001, 1);
        repeat (4) run_round(4'b0011, 1);
        run_round(4'b0011, 3);
        run_round(4'b0011, 1);
        idle_done();
        run_round(4'b0100, 1);
        run_round(4'b0101, 1);
        run_round(4'b0101, 1);
        repeat (60) begin
            run_round(NREQ'($urandom_range(1, 15)), $urandom_range(1, 3));
            if ($urandom_range(0, 3) == 0) idle_done();
        end
        req = 4'b1000;
        w = rr(req);
        tick();
        check("gnt_pre_abort", gnt, NREQ'(1) << w);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        req = '0;
        tick();
        rst_n  = 1'b1;
        m_ptr  = 0;
        exp_st = '0;
        run_round(4'b1111, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/tbc_arbiter.md
# tbc_arbiter

Round-robin arbiter and sequencer that shares one masked SKINNY tweakable block cipher core (`MSK_FSM`, d shares) between NREQ mode-level requesters, e.g. a Romulus-N encrypt channel and a decrypt channel. It grants the core to one requester at a time and multiplexes that requester's tweakeys and masked state onto the core. It generates the core's start and reset controls and routes the core's done and result back to the granted requester. A requester may hold the grant across consecutive core calls, so a full message runs without interleaving.

## Interface
Parameters:
- NREQ, 2, number of requesters (2..8)
- D, 2, number of masking shares
- W, 128, block / tweakey width in bits

Ports:
- clk  in  1  clock, all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- req  in  NREQ  per-requester call request; held until matching done_out
- hold  in  NREQ  keep grant after the current call completes
- tk1_in  in  NREQ*W  TK1 per requester (slice i = bits W*i+:W)
- tk2_in  in  NREQ*W  TK2 per requester
- tk3_in  in  NREQ*W*D  masked key per requester
- st_in  in  NREQ*W*D  masked input state per requester
- gnt  out  NREQ  one-hot grant, registered
- done_out  out  NREQ  one-cycle completion pulse to the granted requester
- st_out  out  W*D  registered masked result of the last call
- busy  out  1  any grant active
- core_start, core_reset  out  1  to the core
- core_tk1, core_tk2  out  W  muxed TK1/TK2
- core_tk3, core_st  out  W*D  muxed masked key/state
- core_st_out  in  W*D  core result
- core_done  in  1  core completion, valid for one cycle

## Operation
- States: IDLE, ISSUE, WAIT, HOLD.
- IDLE: gnt=0, core_reset=1. If any req bit is set, select the first set bit searching ptr, ptr+1, … modulo NREQ. Register gnt to that bit and go to ISSUE.
- ISSUE (one cycle): core_start=1, core_reset=0 → WAIT.
- WAIT: core_reset=0. On core_done, capture core_st_out into st_out and pulse done_out[g] in the following cycle.
  - If hold[g]=1 in the core_done cycle → HOLD.
  - Otherwise release: gnt=0, ptr=(g+1) mod NREQ → IDLE.
- HOLD: gnt kept, core_reset=0.
  - If req[g]=1 → ISSUE.
  - Else if hold[g]=0 → release (same ptr update) → IDLE.
- Operand mux: core_tk1/tk2/tk3/core_st = slice of gnt index. All zero when gnt=0, so no share is forwarded unselected.
- Requester obligations:
  - Keep inputs stable from gnt rising until done_out.
  - Drop req in the cycle done_out is seen, unless it issues another call.
- req deassert during ISSUE/WAIT is ignored; the call completes and done_out still pulses.
- hold of non-granted requesters is ignored.
- core_done outside WAIT is ignored and st_out is unchanged.

## Timing
- Reset values: gnt=0, done_out=0, st_out=0, busy=0, core_start=0, core_reset=1, ptr=0, state IDLE.
- Reset mid-call aborts immediately. core_reset=1 is asserted combinationally while in reset.
- req seen in IDLE at cycle t → gnt and core_start at t+1; core_start is high exactly one cycle.
- core_done at cycle c → done_out and st_out valid at c+1.
  - Release: gnt low at c+1, so another requester can be granted at c+2 and can start at c+2.
- Held back-to-back call: req[g] high at c+1 → ISSUE at c+2. Fixed 2-cycle overhead per call.
- busy = |gnt.
- Simultaneous requests: exactly one is granted, in round-robin order. No requester waits more than NREQ-1 grants.

## Test plan
- Reset, then no requests: gnt=0, core_reset=1, core_start never pulses; assert/deassert rst_n mid-WAIT returns all outputs to reset values in the same cycle.
- req=01, core_done 5 cycles after core_start: gnt=01 at t+1, core_start one cycle, done_out=01 with st_out = core_st_out value (e.g. 0xA5…A5 shares) one cycle after core_done, gnt=00 next.
- req=11 constantly, hold=00: grants alternate 01,10,01,10; each grant exactly one call.
- Requester 1 with hold=10 for 3 calls while req[0]=1: gnt stays 10 for all 3 calls, then 01 is granted 2 cycles after the third done.
- Granted requester drops req during WAIT: call completes, done_out pulses, grant released; core_done injected in IDLE leaves st_out unchanged.
- NREQ=4, ptr=3, req=0101 → gnt=0001, next grant 0100.
